// File: rtl/hex_disp_pkg.sv
// Shared definitions for the scrolling HEX display: character codes,
// active-low 7-segment glyphs ({g,f,e,d,c,b,a}) and the code-to-glyph lookup.
package hex_disp_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [2:0] {
        CH_D      = 3'd0,
        CH_E      = 3'd1,
        CH_ONE    = 3'd2,
        CH_BLANK  = 3'd3,
        CH_H      = 3'd4,
        CH_L      = 3'd5,
        CH_ZERO   = 3'd6,
        CH_BLANK2 = 3'd7
    } char_code_e;

    localparam int   BLANK_CODE = 3;
    localparam seg_t SEG_OFF    = 7'h7F;

    localparam seg_t GLYPH_D    = 7'b0100001;
    localparam seg_t GLYPH_E    = 7'b0000110;
    localparam seg_t GLYPH_ONE  = 7'b1111001;
    localparam seg_t GLYPH_H    = 7'b0001001;
    localparam seg_t GLYPH_L    = 7'b1000111;
    localparam seg_t GLYPH_ZERO = 7'b1000000;

    function automatic seg_t glyph(input logic [2:0] code);
        seg_t g;
        case (char_code_e'(code))
            CH_D:    g = GLYPH_D;
            CH_E:    g = GLYPH_E;
            CH_ONE:  g = GLYPH_ONE;
            CH_H:    g = GLYPH_H;
            CH_L:    g = GLYPH_L;
            CH_ZERO: g = GLYPH_ZERO;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/char_7seg.sv
// Combinational character-code to active-low 7-segment glyph decoder.
// Narrow (2-bit) codes are zero-extended, so they only ever reach codes 0-3.
module char_7seg
    import hex_disp_pkg::*;
#(
    parameter int CHAR_W = 3
) (
    input  logic [CHAR_W-1:0] code,
    output logic [6:0]        seg
);

    logic [2:0] code3;

    assign code3 = 3'(code);
    assign seg   = glyph(code3);

endmodule

// File: rtl/hex_scroll_display.sv
// Scrolling message window on active-low 7-seg displays: message register,
// scroll divider, window position counter, per-digit window mux and decoders.
module hex_scroll_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_CHARS  = 5,
    parameter int CHAR_W     = 3,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [NUM_CHARS*CHAR_W-1:0]   msg,
    input  logic                          en,
    input  logic                          step,
    input  logic                          dir,
    output logic [NUM_DIGITS*7-1:0]       segs,
    output logic [$clog2(NUM_CHARS)-1:0]  pos,
    output logic                          wrap
);

    localparam int POS_W = $clog2(NUM_CHARS);
    localparam int IDX_W = POS_W + 1;
    localparam int DIV_W = $clog2(TICK_DIV);

    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(NUM_CHARS - 1);
    localparam logic [DIV_W-1:0]  LAST_DIV = DIV_W'(TICK_DIV - 1);
    localparam logic [CHAR_W-1:0] BLANK    = CHAR_W'(BLANK_CODE);

    logic [NUM_CHARS-1:0][CHAR_W-1:0] msg_q;
    logic [DIV_W-1:0]                 div_cnt;
    logic                             tick;
    logic                             advance;
    logic [POS_W-1:0]                 pos_next;
    logic [NUM_DIGITS-1:0][6:0]       glyphs;

    assign tick    = en & (div_cnt == LAST_DIV);
    assign advance = (tick | step) & ~load;

    always_comb begin
        if (dir) begin
            pos_next = (pos == '0) ? LAST_POS : pos - POS_W'(1);
        end else begin
            pos_next = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
        end
    end

    // Reset beats load, load beats any advance; wrap is a registered pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_q   <= {NUM_CHARS{BLANK}};
            pos     <= '0;
            div_cnt <= '0;
            wrap    <= 1'b0;
        end else if (load) begin
            msg_q   <= msg;
            pos     <= '0;
            div_cnt <= '0;
            wrap    <= 1'b0;
        end else begin
            if (en) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            end
            if (advance) begin
                pos <= pos_next;
            end
            wrap <= advance & (pos_next == '0);
        end
    end

    // Each digit's offset is folded into range at elaboration, so the runtime
    // index needs at most one conditional subtract.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        localparam int D_OFF = d % NUM_CHARS;

        logic [IDX_W-1:0]  sum;
        logic [POS_W-1:0]  idx;
        logic [CHAR_W-1:0] code;

        always_comb begin
            sum = {1'b0, pos} + IDX_W'(D_OFF);
            if (sum >= IDX_W'(NUM_CHARS)) begin
                sum = sum - IDX_W'(NUM_CHARS);
            end
        end

        assign idx  = sum[POS_W-1:0];
        assign code = msg_q[idx];

        char_7seg #(.CHAR_W(CHAR_W)) u_dec (
            .code (code),
            .seg  (glyphs[d])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            segs <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            segs <= glyphs;
        end
    end

endmodule

// File: tb/tb_hex_scroll_display.sv
// Scoreboard bench for hex_scroll_display: directed scenarios then random
// traffic, checked against a modular-arithmetic reference model.
module tb_hex_scroll_display;

    localparam int ND = 4;
    localparam int NC = 5;
    localparam int CW = 3;
    localparam int TD = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            load  = 1'b0;
    logic            en    = 1'b0;
    logic            step  = 1'b0;
    logic            dir   = 1'b0;
    logic [NC*CW-1:0] msg  = '0;
    logic [ND*7-1:0] segs;
    logic [2:0]      pos;
    logic            wrap;

    hex_scroll_display #(
        .NUM_DIGITS (ND),
        .NUM_CHARS  (NC),
        .CHAR_W     (CW),
        .TICK_DIV   (TD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .msg   (msg),
        .en    (en),
        .step  (step),
        .dir   (dir),
        .segs  (segs),
        .pos   (pos),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ND*7-1:0] segs;
        logic [2:0]      pos;
        logic            wrap;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    logic [6:0] glyph_tab [8] = '{7'h21, 7'h06, 7'h79, 7'h7F, 7'h09, 7'h47, 7'h40, 7'h7F};

    int m_msg [NC];
    int m_pos = 0;
    int m_div = 0;

    // One clock of stimulus; the model's post-edge view goes to the scoreboard.
    task automatic drive(input logic r, input logic l, input logic e, input logic s,
                         input logic dr, input logic [NC*CW-1:0] m);
        exp_t x;
        logic tk;
        @(negedge clk);
        reset = r; load = l; en = e; step = s; dir = dr; msg = m;
        cyc++;
        x.cyc  = cyc;
        x.wrap = 1'b0;
        if (r) begin
            m_pos  = 0;
            m_div  = 0;
            for (int i = 0; i < NC; i++) m_msg[i] = 3;
            x.segs = '1;
        end else begin
            for (int d = 0; d < ND; d++) x.segs[d*7 +: 7] = glyph_tab[m_msg[(m_pos + d) % NC]];
            tk = e && (m_div == TD - 1);
            if (l) begin
                for (int i = 0; i < NC; i++) m_msg[i] = int'(m[i*CW +: CW]);
                m_pos = 0;
                m_div = 0;
            end else begin
                if (e) m_div = (m_div + 1) % TD;
                if (tk || s) begin
                    m_pos  = dr ? (m_pos + NC - 1) % NC : (m_pos + 1) % NC;
                    x.wrap = (m_pos == 0);
                end
            end
        end
        x.pos = 3'(m_pos);
        sb.push_back(x);
    endtask

    task automatic check(input string name, input int c, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, want);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("segs", x.cyc, 32'(segs), 32'(x.segs));
                check("pos",  x.cyc, 32'(pos),  32'(x.pos));
                check("wrap", x.cyc, 32'(wrap), 32'(x.wrap));
            end
        end
    end

    logic [NC*CW-1:0] hello;
    logic [NC*CW-1:0] rmsg;
    int               hello_codes [NC] = '{4, 5, 5, 6, 3};

    initial begin
        for (int i = 0; i < NC; i++) hello[i*CW +: CW] = CW'(hello_codes[i]);

        // held reset must ignore load/step
        drive(1, 1, 1, 1, 0, hello);
        drive(1, 1, 1, 1, 0, hello);

        // load then idle until glyphs appear
        drive(0, 1, 0, 0, 0, hello);
        drive(0, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 0, '0);

        // auto scroll left through a full wrap
        for (int i = 0; i < 24; i++) drive(0, 0, 1, 0, 0, '0);

        // manual right step from 0, then steps colliding with ticks
        drive(0, 1, 0, 0, 0, hello);
        drive(0, 0, 0, 1, 1, '0);
        drive(0, 0, 0, 0, 1, '0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 1, 1, '0);

        // pause at divider=2 then resume
        drive(0, 1, 0, 0, 0, hello);
        drive(0, 0, 1, 0, 0, '0);
        drive(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0, '0);

        // load on the same cycle as tick+step, then reset mid-scroll
        drive(0, 1, 0, 0, 0, hello);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, '0);
        drive(0, 1, 1, 1, 0, hello);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0, '0);
        drive(1, 0, 1, 0, 0, '0);
        drive(0, 0, 1, 0, 0, '0);

        for (int i = 0; i < 400; i++) begin
            rmsg = (NC*CW)'($urandom);
            drive(($urandom % 50) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
                  ($urandom % 6) == 0, 1'($urandom), rmsg);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
